// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single data-memory port: latch, issue for one cycle, acknowledge.
// Load data is captured at the end of the access and presented registered one cycle later.
module dmem_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter bit          RR_EN  = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [2:0]        m0_s_type,
   input  logic [2:0]        m0_l_type,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [2:0]        m1_s_type,
   input  logic [2:0]        m1_l_type,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              mem_write_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [2:0]        s_type,
   output logic [2:0]        l_type,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic {ARB, ACCESS} state_t;

   state_t              state, state_nx;
   logic                last_served, last_served_nx;
   logic                owner, owner_nx;
   logic                pick_m1_c;
   logic                m0_gnt_nx, m1_gnt_nx, m0_rvalid_nx, m1_rvalid_nx;
   logic [DATA_W-1:0]   m0_rdata_nx, m1_rdata_nx;
   logic                mem_write_en_nx;
   logic [ADDR_W-1:0]   mem_addr_nx;
   logic [DATA_W-1:0]   mem_wdata_nx;
   logic [2:0]          s_type_nx, l_type_nx;

   // m1 wins when alone, or on a tie when rotating and m0 was served last
   assign pick_m1_c = m1_req && (!m0_req || (RR_EN && (last_served == 1'b0)));

   always_comb begin
      state_nx        = state;
      last_served_nx  = last_served;
      owner_nx        = owner;
      m0_gnt_nx       = 1'b0;
      m1_gnt_nx       = 1'b0;
      m0_rvalid_nx    = 1'b0;
      m1_rvalid_nx    = 1'b0;
      m0_rdata_nx     = m0_rdata;
      m1_rdata_nx     = m1_rdata;
      mem_write_en_nx = 1'b0;
      mem_addr_nx     = '0;
      mem_wdata_nx    = '0;
      s_type_nx       = '0;
      l_type_nx       = '0;
      case (state)
         ARB: begin
            if (m0_req || m1_req) begin
               state_nx        = ACCESS;
               owner_nx        = pick_m1_c;
               m0_gnt_nx       = !pick_m1_c;
               m1_gnt_nx       = pick_m1_c;
               mem_write_en_nx = pick_m1_c ? m1_we     : m0_we;
               mem_addr_nx     = pick_m1_c ? m1_addr   : m0_addr;
               mem_wdata_nx    = pick_m1_c ? m1_wdata  : m0_wdata;
               s_type_nx       = pick_m1_c ? m1_s_type : m0_s_type;
               l_type_nx       = pick_m1_c ? m1_l_type : m0_l_type;
            end
         end
         ACCESS: begin
            state_nx       = ARB;
            last_served_nx = owner;
            if (!mem_write_en) begin
               if (owner) begin
                  m1_rdata_nx  = mem_rdata;
                  m1_rvalid_nx = 1'b1;
               end else begin
                  m0_rdata_nx  = mem_rdata;
                  m0_rvalid_nx = 1'b1;
               end
            end
         end
         default: state_nx = ARB;
      endcase
   end

   // mem_* registers double as the request registers; they read zero outside ACCESS
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ARB;
         last_served  <= 1'b1;
         owner        <= 1'b0;
         m0_gnt       <= 1'b0;
         m1_gnt       <= 1'b0;
         m0_rvalid    <= 1'b0;
         m1_rvalid    <= 1'b0;
         m0_rdata     <= '0;
         m1_rdata     <= '0;
         mem_write_en <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         s_type       <= '0;
         l_type       <= '0;
      end else begin
         state        <= state_nx;
         last_served  <= last_served_nx;
         owner        <= owner_nx;
         m0_gnt       <= m0_gnt_nx;
         m1_gnt       <= m1_gnt_nx;
         m0_rvalid    <= m0_rvalid_nx;
         m1_rvalid    <= m1_rvalid_nx;
         m0_rdata     <= m0_rdata_nx;
         m1_rdata     <= m1_rdata_nx;
         mem_write_en <= mem_write_en_nx;
         mem_addr     <= mem_addr_nx;
         mem_wdata    <= mem_wdata_nx;
         s_type       <= s_type_nx;
         l_type       <= l_type_nx;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance drives a small word memory,
// a fixed-priority instance shares the same request stimulus.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_clear = 1'b1;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [2:0]  m0_s_type, m0_l_type, m1_s_type, m1_l_type;

   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_write_en;
   logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [2:0]  s_type, l_type;

   logic        fp_m0_gnt, fp_m1_gnt, fp_m0_rvalid, fp_m1_rvalid, fp_mem_write_en;
   logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_mem_addr, fp_mem_wdata, fp_mem_rdata;
   logic [2:0]  fp_s_type, fp_l_type;

   logic [31:0] mem [0:63];
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   // word memory preset to 0xA000_0000 | word index
   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 | 32'(i);
      end else if (mem_write_en) begin
         mem[mem_addr[7:2]] <= mem_wdata;
      end
   end
   assign mem_rdata    = mem[mem_addr[7:2]];
   assign fp_mem_rdata = mem[fp_mem_addr[7:2]];

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b1)) u_rr (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_s_type(m0_s_type), .m0_l_type(m0_l_type),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_s_type(m1_s_type), .m1_l_type(m1_l_type),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_write_en(mem_write_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .s_type(s_type), .l_type(l_type), .mem_rdata(mem_rdata)
   );

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b0)) u_fp (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_s_type(m0_s_type), .m0_l_type(m0_l_type),
      .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid), .m0_rdata(fp_m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_s_type(m1_s_type), .m1_l_type(m1_l_type),
      .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid), .m1_rdata(fp_m1_rdata),
      .mem_write_en(fp_mem_write_en), .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata),
      .s_type(fp_s_type), .l_type(fp_l_type), .mem_rdata(fp_mem_rdata)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      m0_req = 1'b0;
      m1_req = 1'b0;
      reset  = 1'b0;
      tick();
      reset  = 1'b1;
   endtask

   task automatic test_reset();
      m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_s_type = '0; m0_l_type = '0;
      m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_s_type = '0; m1_l_type = '0;
      #1 reset = 1'b0;
      #1;
      total++;
      if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_write_en} !== 5'b0) begin
         bad++; $display("FAIL reset_ctrl: got %b expected 00000",
                         {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_write_en});
      end
      total++;
      if ({mem_addr, mem_wdata, s_type, l_type} !== 70'd0) begin
         bad++; $display("FAIL reset_mem_bus: addr=%h wdata=%h s=%b l=%b expected zero",
                         mem_addr, mem_wdata, s_type, l_type);
      end
      total++;
      if ({m0_rdata, m1_rdata} !== 64'd0) begin
         bad++; $display("FAIL reset_rdata: got %h %h expected 0", m0_rdata, m1_rdata);
      end
      tick(); tick();
      mem_clear = 1'b0;
      reset = 1'b1;
   endtask

   task automatic test_store_load();
      m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF; m0_s_type = 3'b010;
      tick();
      total++;
      if ({m0_gnt, m1_gnt, mem_write_en} !== 3'b101) begin
         bad++; $display("FAIL st_gnt: got gnt0/gnt1/we=%b expected 101", {m0_gnt, m1_gnt, mem_write_en});
      end
      total++;
      if (mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF || s_type !== 3'b010) begin
         bad++; $display("FAIL st_bus: got addr=%h wdata=%h s=%b expected 10 deadbeef 010",
                         mem_addr, mem_wdata, s_type);
      end
      m0_we = 0; m0_s_type = 3'b000; m0_l_type = 3'b010;
      tick();
      total++;
      if ({m0_gnt, mem_write_en, m0_rvalid} !== 3'b000 || mem_addr !== 32'h0) begin
         bad++; $display("FAIL st_idle: got gnt/we/rvalid=%b addr=%h expected 000 0",
                         {m0_gnt, mem_write_en, m0_rvalid}, mem_addr);
      end
      tick();
      total++;
      if ({m0_gnt, mem_write_en} !== 2'b10 || mem_addr !== 32'h10 || l_type !== 3'b010) begin
         bad++; $display("FAIL ld_access: got gnt/we=%b addr=%h l=%b expected 10 10 010",
                         {m0_gnt, mem_write_en}, mem_addr, l_type);
      end
      m0_req = 0;
      tick();
      total++;
      if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF || m1_rvalid !== 1'b0) begin
         bad++; $display("FAIL ld_rvalid: got rv=%b data=%h rv1=%b expected 1 deadbeef 0",
                         m0_rvalid, m0_rdata, m1_rvalid);
      end
      tick();
      total++;
      if (m0_rvalid !== 1'b0 || m0_gnt !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin
         bad++; $display("FAIL ld_hold: got rv=%b gnt=%b data=%h expected 0 0 deadbeef",
                         m0_rvalid, m0_gnt, m0_rdata);
      end
   endtask

   task automatic test_tie();
      logic        exp1;
      logic [31:0] exp_data;
      apply_reset();
      m0_req = 1; m0_we = 0; m0_addr = 32'h10; m0_l_type = 3'b010;
      m1_req = 1; m1_we = 0; m1_addr = 32'h20; m1_l_type = 3'b010;
      for (int i = 0; i < 4; i++) begin
         exp1 = (i % 2) == 1;
         exp_data = exp1 ? 32'hA000_0008 : 32'hDEADBEEF;
         tick();
         total++;
         if ({m0_gnt, m1_gnt} !== {!exp1, exp1}) begin
            bad++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, {m0_gnt, m1_gnt}, {!exp1, exp1});
         end
         total++;
         if ({fp_m0_gnt, fp_m1_gnt} !== 2'b10) begin
            bad++; $display("FAIL fp_gnt[%0d]: got %b expected 10", i, {fp_m0_gnt, fp_m1_gnt});
         end
         tick();
         total++;
         if ({m0_rvalid, m1_rvalid} !== {!exp1, exp1} ||
             (exp1 ? m1_rdata : m0_rdata) !== exp_data) begin
            bad++; $display("FAIL rr_rvalid[%0d]: got rv=%b data=%h expected %b %h", i,
                            {m0_rvalid, m1_rvalid}, exp1 ? m1_rdata : m0_rdata, {!exp1, exp1}, exp_data);
         end
         total++;
         if ({fp_m1_gnt, fp_m1_rvalid, fp_m0_rvalid} !== 3'b001) begin
            bad++; $display("FAIL fp_rvalid[%0d]: got gnt1/rv1/rv0=%b expected 001", i,
                            {fp_m1_gnt, fp_m1_rvalid, fp_m0_rvalid});
         end
      end
      m0_req = 0; m1_req = 0;
      tick(); tick();
   endtask

   task automatic test_nonowner();
      apply_reset();
      m0_req = 1; m0_we = 0; m0_addr = 32'h20;
      m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h12345678; m1_s_type = 3'b010;
      tick();
      total++;
      if ({m0_gnt, m1_gnt, mem_write_en} !== 3'b100 || mem_addr !== 32'h20) begin
         bad++; $display("FAIL no_first: got gnt0/gnt1/we=%b addr=%h expected 100 20",
                         {m0_gnt, m1_gnt, mem_write_en}, mem_addr);
      end
      m0_req = 0;
      tick();
      total++;
      if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hA000_0008 || m1_rvalid !== 1'b0) begin
         bad++; $display("FAIL no_old: got rv0=%b data=%h rv1=%b expected 1 a0000008 0",
                         m0_rvalid, m0_rdata, m1_rvalid);
      end
      tick();
      total++;
      if ({m0_gnt, m1_gnt, mem_write_en} !== 3'b011 || mem_wdata !== 32'h12345678) begin
         bad++; $display("FAIL no_store: got gnt0/gnt1/we=%b wdata=%h expected 011 12345678",
                         {m0_gnt, m1_gnt, mem_write_en}, mem_wdata);
      end
      m1_req = 0; m0_req = 1;
      tick();
      total++;
      if (m1_rvalid !== 1'b0) begin
         bad++; $display("FAIL no_st_rvalid: got %b expected 0", m1_rvalid);
      end
      tick();
      m0_req = 0;
      tick();
      total++;
      if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h12345678 || m1_rvalid !== 1'b0) begin
         bad++; $display("FAIL no_new: got rv0=%b data=%h rv1=%b expected 1 12345678 0",
                         m0_rvalid, m0_rdata, m1_rvalid);
      end
   endtask

   task automatic test_reset_mid_access();
      m1_req = 1; m1_we = 1; m1_addr = 32'h30; m1_wdata = 32'hCAFEF00D;
      tick();
      total++;
      if ({m1_gnt, mem_write_en} !== 2'b11) begin
         bad++; $display("FAIL rm_access: got gnt1/we=%b expected 11", {m1_gnt, mem_write_en});
      end
      #2 reset = 1'b0;
      #1;
      total++;
      if ({m1_gnt, mem_write_en} !== 2'b00 || mem_addr !== 32'h0 || m0_rdata !== 32'h0) begin
         bad++; $display("FAIL rm_async: got gnt1/we=%b addr=%h rdata0=%h expected 00 0 0",
                         {m1_gnt, mem_write_en}, mem_addr, m0_rdata);
      end
      m1_req = 0;
      tick();
      total++;
      if (mem[12] !== 32'hA000_000C) begin
         bad++; $display("FAIL rm_mem: got %h expected a000000c", mem[12]);
      end
      reset = 1'b1;
      m0_req = 1; m0_we = 0; m0_addr = 32'h10;
      m1_req = 1; m1_we = 0; m1_addr = 32'h30;
      tick();
      total++;
      if ({m0_gnt, m1_gnt} !== 2'b10) begin
         bad++; $display("FAIL rm_tie: got %b expected 10", {m0_gnt, m1_gnt});
      end
      m0_req = 0; m1_req = 0;
      tick(); tick(); tick();
   endtask

   task automatic test_back_to_back();
      apply_reset();
      m0_req = 1; m0_we = 1; m0_addr = 32'h40; m0_wdata = 32'h1111_0040;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if (m0_gnt !== 1'b1 || mem_addr !== 32'h40 + 32'(4 * i)) begin
            bad++; $display("FAIL b2b_gnt[%0d]: got gnt=%b addr=%h expected 1 %h",
                            i, m0_gnt, mem_addr, 32'h40 + 32'(4 * i));
         end
         m0_addr  = 32'h40 + 32'(4 * (i + 1));
         m0_wdata = 32'h1111_0040 + 32'(4 * (i + 1));
         if (i == 3) m0_req = 0;
         tick();
         total++;
         if ({m0_gnt, mem_write_en} !== 2'b00) begin
            bad++; $display("FAIL b2b_gap[%0d]: got gnt/we=%b expected 00", i, {m0_gnt, mem_write_en});
         end
      end
      tick();
      total++;
      if (m0_gnt !== 1'b0) begin
         bad++; $display("FAIL b2b_noreissue: got gnt=%b expected 0", m0_gnt);
      end
      for (int i = 0; i < 5; i++) begin
         total++;
         if (mem[16 + i] !== (i < 4 ? 32'h1111_0040 + 32'(4 * i) : 32'hA000_0014)) begin
            bad++; $display("FAIL b2b_mem[%0d]: got %h", i, mem[16 + i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_tie();
      test_nonowner();
      test_reset_mid_access();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

endmodule
